// File: rtl/seq_alu_if.sv
// Handshake and data bundle between the control unit / register file and seq_alu.
interface seq_alu_if #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 2
) ();
    logic         Start;
    logic [2:0]   Op;
    logic [W-1:0] DataA;
    logic [W-1:0] DataB;
    logic [A-1:0] Dst;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result;
    logic         WrEn;
    logic [A-1:0] WrAddr;
    logic [W-1:0] WrData;
    logic         Carry;
    logic         Zero;

    modport master (
        output Start, Op, DataA, DataB, Dst,
        input  Busy, Done, Result, WrEn, WrAddr, WrData, Carry, Zero
    );

    modport slave (
        input  Start, Op, DataA, DataB, Dst,
        output Busy, Done, Result, WrEn, WrAddr, WrData, Carry, Zero
    );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith ops, bit-serial shifts/rotates, register-file writeback.
// Optional SEQ_ALU_FLAGS_EN adds registered Carry/Zero flags.
module seq_alu #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 2
) (
    input logic   Clk,
    input logic   Reset_n,
    seq_alu_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SLL   = 3'b100;
    localparam logic [2:0] OP_SRL   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    logic [1:0]   state_q, state_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] acc_q, acc_d;
    logic [A-1:0] dst_q, dst_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [W-1:0] result_q, result_d;
    logic [W-1:0] alu_res;
    logic         op_is_shift;

`ifdef SEQ_ALU_FLAGS_EN
    logic cy_q, cy_d;
    logic carry_q, carry_d;
    logic zero_q, zero_d;
    logic alu_cy;
`endif

    assign op_is_shift = bus.Op[2] && (bus.Op[1:0] != 2'b11);

    // Single-cycle result from the live operands; shifts start from A unchanged.
    always_comb begin
        alu_res = bus.DataA;
`ifdef SEQ_ALU_FLAGS_EN
        alu_cy  = 1'b0;
`endif
        unique case (bus.Op)
`ifdef SEQ_ALU_FLAGS_EN
            OP_ADD:   {alu_cy, alu_res} = {1'b0, bus.DataA} + {1'b0, bus.DataB};
            OP_SUB:   {alu_cy, alu_res} = {1'b0, bus.DataA} - {1'b0, bus.DataB};
`else
            OP_ADD:   alu_res = bus.DataA + bus.DataB;
            OP_SUB:   alu_res = bus.DataA - bus.DataB;
`endif
            OP_AND:   alu_res = bus.DataA & bus.DataB;
            OP_XOR:   alu_res = bus.DataA ^ bus.DataB;
            OP_PASSB: alu_res = bus.DataB;
            default:  alu_res = bus.DataA;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        dst_d    = dst_q;
        cnt_d    = cnt_q;
        result_d = result_q;
`ifdef SEQ_ALU_FLAGS_EN
        cy_d     = cy_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    op_d  = bus.Op;
                    dst_d = bus.Dst;
                    cnt_d = bus.DataB[2:0];
                    acc_d = alu_res;
`ifdef SEQ_ALU_FLAGS_EN
                    cy_d  = alu_cy;
`endif
                    state_d = (op_is_shift && (bus.DataB[2:0] != 3'd0)) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                unique case (op_q)
                    OP_SLL:  acc_d = {acc_q[W-2:0], 1'b0};
                    OP_SRL:  acc_d = {1'b0, acc_q[W-1:1]};
                    OP_ROL:  acc_d = {acc_q[W-2:0], acc_q[W-1]};
                    default: acc_d = acc_q;
                endcase
`ifdef SEQ_ALU_FLAGS_EN
                cy_d = (op_q == OP_SRL) ? acc_q[0] : acc_q[W-1];
`endif
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Result and flags become visible in the DONE cycle and hold until the next one.
        if (state_d == ST_DONE) begin
            result_d = acc_d;
`ifdef SEQ_ALU_FLAGS_EN
            carry_d  = (op_d == OP_ROL) ? acc_d[0] : cy_d;
            zero_d   = (acc_d == '0);
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
`ifdef SEQ_ALU_FLAGS_EN
            cy_q     <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
`ifdef SEQ_ALU_FLAGS_EN
            cy_q     <= cy_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.Busy   = (state_q != ST_IDLE);
    assign bus.Done   = (state_q == ST_DONE);
    assign bus.WrEn   = (state_q == ST_DONE);
    assign bus.Result = result_q;
    assign bus.WrData = result_q;
    assign bus.WrAddr = dst_q;
`ifdef SEQ_ALU_FLAGS_EN
    assign bus.Carry  = carry_q;
    assign bus.Zero   = zero_q;
`else
    assign bus.Carry  = 1'b0;
    assign bus.Zero   = 1'b0;
`endif
endmodule
